// File: rtl/addr_pkg.sv
// rtl/addr_pkg.sv - shared modes, register addresses and status bit indices for addr_pipe_unit
package addr_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'd0,
        MODE_ADD_OFF = 2'd1,
        MODE_SUB     = 2'd2,
        MODE_SAT     = 2'd3
    } mode_e;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_OFFSET = 3'd1;
    localparam logic [2:0] ADDR_GP     = 3'd2;
    localparam logic [2:0] ADDR_COUNT  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam int STAT_OVF_BIT  = 0;
    localparam int STAT_BUSY_BIT = 1;

endpackage

// File: rtl/addr_regbank.sv
// rtl/addr_regbank.sv - register bank: control/offset/gp storage, result counter, sticky status, registered reads
module addr_regbank
    import addr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       des_address,
    input  logic [WIDTH-1:0] des_value,
    input  logic             des_reg_valid,
    input  logic             des_wr_rd,
    input  logic             xfer,
    input  logic             xfer_carry,
    input  logic             busy,
    output mode_e            mode,
    output logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] rd_value,
    output logic             rd_valid
);

    logic [WIDTH-1:0] ctrl_q;
    logic [WIDTH-1:0] offset_q;
    logic [WIDTH-1:0] gp_q;
    logic [WIDTH-1:0] count_q;
    logic             ovf_q;

    logic             wr_en;
    logic             rd_en;
    logic             ovf_clr;
    logic [WIDTH-1:0] status_word;
    logic [WIDTH-1:0] rd_mux;

    assign mode   = mode_e'(ctrl_q[1:0]);
    assign offset = offset_q;

    // Decode the strobe and build the read word from current (pre-update) register values
    always_comb begin
        wr_en       = des_reg_valid && des_wr_rd;
        rd_en       = des_reg_valid && !des_wr_rd;
        ovf_clr     = wr_en && (des_address == ADDR_STATUS) && des_value[STAT_OVF_BIT];
        status_word = '0;
        status_word[STAT_OVF_BIT]  = ovf_q;
        status_word[STAT_BUSY_BIT] = busy;
        rd_mux = '0;
        case (des_address)
            ADDR_CTRL:   rd_mux = ctrl_q;
            ADDR_OFFSET: rd_mux = offset_q;
            ADDR_GP:     rd_mux = gp_q;
            ADDR_COUNT:  rd_mux = count_q;
            ADDR_STATUS: rd_mux = status_word;
            default:     rd_mux = '0;
        endcase
    end

    // Register writes, transfer counter, sticky overflow (set beats clear) and read response
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            offset_q <= '0;
            gp_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rd_value <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en && des_address == ADDR_CTRL)   ctrl_q   <= des_value;
            if (wr_en && des_address == ADDR_OFFSET) offset_q <= des_value;
            if (wr_en && des_address == ADDR_GP)     gp_q     <= des_value;
            if (xfer) count_q <= count_q + WIDTH'(1);
            ovf_q    <= (xfer && xfer_carry) || (ovf_q && !ovf_clr);
            rd_valid <= rd_en;
            if (rd_en) rd_value <= rd_mux;
        end
    end

endmodule

// File: rtl/addr_pipe_unit.sv
// rtl/addr_pipe_unit.sv - pipelined add/add-offset/subtract unit with register bank; ADDR_SAT_EN enables saturating mode 3
module addr_pipe_unit
    import addr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Value_a,
    input  logic [WIDTH-1:0] Value_b,
    input  logic             Data_val,
    output logic             Data_rdy,
    output logic [WIDTH-1:0] Sum_result,
    output logic             Sum_carry,
    output logic             Sum_val,
    input  logic             Sum_rdy,
    input  logic [2:0]       Des_address,
    input  logic [WIDTH-1:0] Des_value,
    input  logic             Des_reg_valid,
    input  logic             Des_wr_rd,
    output logic [WIDTH-1:0] Des_rd_value,
    output logic             Des_rd_valid
);

    logic [WIDTH-1:0] res_q [PIPE];
    logic [PIPE-1:0]  cry_q;
    logic [PIPE-1:0]  vld_q;

    mode_e            mode;
    logic [WIDTH-1:0] offset;
    logic             advance;
    logic             accept;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH+1:0] sum_off;
    logic [WIDTH-1:0] calc_res;
    logic             calc_cry;

    assign advance    = !vld_q[PIPE-1] || Sum_rdy;
    assign Data_rdy   = advance && !reset;
    assign accept     = Data_val && Data_rdy;
    assign Sum_result = res_q[PIPE-1];
    assign Sum_carry  = cry_q[PIPE-1];
    assign Sum_val    = vld_q[PIPE-1];

    // Result is computed at acceptance so mode/offset are frozen with the operands
    always_comb begin
        sum_ab   = {1'b0, Value_a} + {1'b0, Value_b};
        sum_off  = {2'b00, Value_a} + {2'b00, Value_b} + {2'b00, offset};
        calc_res = sum_ab[WIDTH-1:0];
        calc_cry = sum_ab[WIDTH];
        case (mode)
            MODE_ADD_OFF: begin
                calc_res = sum_off[WIDTH-1:0];
                calc_cry = |sum_off[WIDTH+1:WIDTH];
            end
            MODE_SUB: begin
                calc_res = Value_a - Value_b;
                calc_cry = Value_a < Value_b;
            end
            MODE_SAT: begin
`ifdef ADDR_SAT_EN
                calc_res = sum_ab[WIDTH] ? {WIDTH{1'b1}} : sum_ab[WIDTH-1:0];
                calc_cry = sum_ab[WIDTH];
`else
                calc_res = sum_ab[WIDTH-1:0];
                calc_cry = sum_ab[WIDTH];
`endif
            end
            default: begin
                calc_res = sum_ab[WIDTH-1:0];
                calc_cry = sum_ab[WIDTH];
            end
        endcase
    end

    // Shift register pipeline; every stage moves together only when the output can advance
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            cry_q <= '0;
            for (int i = 0; i < PIPE; i++) res_q[i] <= '0;
        end else if (advance) begin
            vld_q[0] <= accept;
            cry_q[0] <= calc_cry;
            res_q[0] <= calc_res;
            for (int i = 1; i < PIPE; i++) begin
                vld_q[i] <= vld_q[i-1];
                cry_q[i] <= cry_q[i-1];
                res_q[i] <= res_q[i-1];
            end
        end
    end

    addr_regbank #(.WIDTH(WIDTH)) u_regbank (
        .clk           (clk),
        .reset         (reset),
        .des_address   (Des_address),
        .des_value     (Des_value),
        .des_reg_valid (Des_reg_valid),
        .des_wr_rd     (Des_wr_rd),
        .xfer          (Sum_val && Sum_rdy),
        .xfer_carry    (Sum_carry),
        .busy          (|vld_q),
        .mode          (mode),
        .offset        (offset),
        .rd_value      (Des_rd_value),
        .rd_valid      (Des_rd_valid)
    );

endmodule

// File: tb/tb_addr_pipe_unit.sv
// tb/tb_addr_pipe_unit.sv - scoreboard bench for addr_pipe_unit (WIDTH=8, PIPE=2)
module tb_addr_pipe_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Value_a = '0, Value_b = '0;
    logic       Data_val = 1'b0;
    logic       Data_rdy;
    logic [7:0] Sum_result;
    logic       Sum_carry;
    logic       Sum_val;
    logic       Sum_rdy = 1'b1;
    logic [2:0] Des_address = '0;
    logic [7:0] Des_value = '0;
    logic       Des_reg_valid = 1'b0;
    logic       Des_wr_rd = 1'b0;
    logic [7:0] Des_rd_value;
    logic       Des_rd_valid;

    int checks = 0;
    int failures = 0;

    logic [8:0] sb [$];
    logic [7:0] rdq [$];

    logic [7:0] sh_ctrl, sh_off, sh_gp, sh_count;
    bit         sh_ovf;
    bit         prev_stall;
    logic [7:0] prev_res;
    logic       prev_cry;
    logic [8:0] m_e;
    logic [7:0] m_r;
    bit         m_set, m_clr, m_busy, acc;

    addr_pipe_unit #(.WIDTH(8), .PIPE(2)) dut (
        .clk(clk), .reset(reset),
        .Value_a(Value_a), .Value_b(Value_b), .Data_val(Data_val), .Data_rdy(Data_rdy),
        .Sum_result(Sum_result), .Sum_carry(Sum_carry), .Sum_val(Sum_val), .Sum_rdy(Sum_rdy),
        .Des_address(Des_address), .Des_value(Des_value), .Des_reg_valid(Des_reg_valid),
        .Des_wr_rd(Des_wr_rd), .Des_rd_value(Des_rd_value), .Des_rd_valid(Des_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] m, input logic [7:0] off);
        int s;
        int r;
        bit c;
        s = int'(a) + int'(b);
        c = s > 255;
        r = s % 256;
        case (m)
            2'd1: begin s = int'(a) + int'(b) + int'(off); c = s > 255; r = s % 256; end
            2'd2: begin c = a < b; r = (int'(a) - int'(b) + 256) % 256; end
`ifdef ADDR_SAT_EN
            2'd3: begin r = c ? 255 : s; end
`endif
            default: ;
        endcase
        return {c, r[7:0]};
    endfunction

    // Reference scoreboard and register shadow, evaluated on the inactive edge
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            rdq.delete();
            sh_ctrl = '0; sh_off = '0; sh_gp = '0; sh_count = '0; sh_ovf = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_val", Sum_val, 1);
                check("hold_res", Sum_result, prev_res);
                check("hold_cry", Sum_carry, prev_cry);
            end
            if (Des_rd_valid) begin
                if (rdq.size() == 0) check("rd_spurious", 1, 0);
                else begin
                    m_r = rdq.pop_front();
                    check("rd_value", Des_rd_value, m_r);
                end
            end
            if (Des_reg_valid && !Des_wr_rd) begin
                m_busy = sb.size() != 0;
                case (Des_address)
                    3'd0: m_r = sh_ctrl;
                    3'd1: m_r = sh_off;
                    3'd2: m_r = sh_gp;
                    3'd3: m_r = sh_count;
                    3'd4: m_r = {6'b0, m_busy, sh_ovf};
                    default: m_r = '0;
                endcase
                rdq.push_back(m_r);
            end
            m_set = 0;
            if (Sum_val && Sum_rdy) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    m_e = sb.pop_front();
                    check("result", Sum_result, m_e[7:0]);
                    check("carry", Sum_carry, m_e[8]);
                    m_set = m_e[8];
                end
                sh_count = sh_count + 8'd1;
            end
            if (Data_val && Data_rdy)
                sb.push_back(model(Value_a, Value_b, sh_ctrl[1:0], sh_off));
            m_clr = 0;
            if (Des_reg_valid && Des_wr_rd) begin
                case (Des_address)
                    3'd0: sh_ctrl = Des_value;
                    3'd1: sh_off = Des_value;
                    3'd2: sh_gp = Des_value;
                    3'd4: m_clr = Des_value[0];
                    default: ;
                endcase
            end
            sh_ovf = m_set || (sh_ovf && !m_clr);
            prev_stall = Sum_val && !Sum_rdy;
            prev_res = Sum_result;
            prev_cry = Sum_carry;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] v);
        Des_reg_valid = 1; Des_wr_rd = 1; Des_address = a; Des_value = v;
        tick();
        Des_reg_valid = 0;
    endtask

    task automatic reg_rd(input logic [2:0] a);
        Des_reg_valid = 1; Des_wr_rd = 0; Des_address = a;
        tick();
        Des_reg_valid = 0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        Value_a = a; Value_b = b; Data_val = 1;
        tick();
        Data_val = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rdy_in_reset", Data_rdy, 0);
        idle(2);
        reset = 0;
        @(negedge clk);
        check("rst_sum_val", Sum_val, 0);
        check("rst_sum_result", Sum_result, 0);
        check("rst_rd_valid", Des_rd_valid, 0);
        tick();

        // mode 0 wrap with latency check
        Value_a = 8'hFF; Value_b = 8'h01; Data_val = 1;
        tick();
        Data_val = 0;
        @(negedge clk);
        check("lat_early", Sum_val, 0);
        tick();
        @(negedge clk);
        check("lat_val", Sum_val, 1);
        check("ff01_res", Sum_result, 8'h00);
        check("ff01_cry", Sum_carry, 1);
        tick();
        reg_rd(3'd3);
        reg_rd(3'd4);
        idle(2);

        // offset mode, offset rewritten while in flight
        reg_wr(3'd1, 8'h10);
        reg_wr(3'd0, 8'h01);
        send(8'hF0, 8'h10);
        reg_wr(3'd1, 8'h00);
        idle(3);

        // subtract and mode 3
        reg_wr(3'd0, 8'h02);
        send(8'h05, 8'h07);
        send(8'h07, 8'h05);
        reg_wr(3'd0, 8'h03);
        send(8'hC0, 8'h80);
        idle(3);

        // control spare bits, gp, unmapped space
        reg_wr(3'd0, 8'hA4);
        reg_wr(3'd2, 8'h5A);
        reg_wr(3'd5, 8'hAA);
        reg_rd(3'd0);
        reg_rd(3'd2);
        reg_rd(3'd5);
        reg_rd(3'd7);
        idle(2);

        // sticky overflow: clear, then clear colliding with a carry transfer
        reg_wr(3'd0, 8'h00);
        reg_wr(3'd4, 8'h01);
        reg_rd(3'd4);
        idle(1);
        Value_a = 8'hFF; Value_b = 8'h01; Data_val = 1;
        tick();
        Data_val = 0;
        tick();
        reg_wr(3'd4, 8'h01);
        reg_rd(3'd4);
        check("ovf_set_wins", Des_rd_value[0], 1);
        idle(2);

        // back-to-back traffic with a 5-cycle output stall, then random flow control
        Value_a = 8'($urandom); Value_b = 8'($urandom);
        Data_val = 1; Sum_rdy = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            acc = Data_val && Data_rdy;
            if (c >= 3 && c < 8 && Sum_val) check("rdy_during_stall", Data_rdy, 0);
            tick();
            if (acc || !Data_val) begin Value_a = 8'($urandom); Value_b = 8'($urandom); end
            Sum_rdy  = (c >= 2 && c < 7) ? 1'b0 : ((c < 12) ? 1'b1 : ($urandom_range(0, 3) != 0));
            Data_val = (c < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            Des_reg_valid = 0;
            if (c >= 12 && $urandom_range(0, 4) == 0) begin
                Des_reg_valid = 1; Des_wr_rd = 1;
                Des_address = 3'($urandom_range(0, 1));
                Des_value = 8'($urandom);
            end
        end
        Data_val = 0; Des_reg_valid = 0; Sum_rdy = 1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("drained", sb.size(), 0);
        reg_rd(3'd3);
        reg_rd(3'd4);
        idle(2);

        // reset in the middle of a stream
        reg_wr(3'd0, 8'h00);
        Data_val = 1;
        for (int i = 0; i < 3; i++) begin
            Value_a = 8'($urandom); Value_b = 8'($urandom);
            tick();
        end
        reset = 1;
        tick();
        reset = 0; Data_val = 0;
        check("rst_mid_val", Sum_val, 0);
        reg_rd(3'd3);
        check("rst_mid_count", Des_rd_value, 0);
        idle(2);

        check("sb_empty_end", sb.size(), 0);
        check("rdq_empty_end", rdq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
